square_wave_period_meter: RTL

Measures the period and duty of a square-wave audio signal, such as the output of the 555 VCO blocks, and reports high time, low time and period in clk cycles. It sits on the receiving side of an oscillator's 16-bit sample stream. Typical uses are recovering an oscillator's frequency for control loops and self-checking discrete models in hardware. The input is thresholded with 555-style hysteresis (2/3 and 1/3 of VCC = 16384) before its edges are timed.

---
 rtl/discrete_pkg.sv | 15 +
 rtl/schmitt_level_detector.sv | 44 ++++
 rtl/square_wave_period_meter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/discrete_pkg.sv
// Shared types and analog-level constants for the discrete oscillator blocks.
// VCC maps to a 16-bit sample value of 16384.
package discrete_pkg;

  typedef enum logic [1:0] {
    SYNC,
    HIGH,
    LOW
  } meter_state_t;

  localparam logic signed [15:0] VCC     = 16'sd16384;
  localparam logic signed [15:0] VCC_2_3 = 16'sd10923;
  localparam logic signed [15:0] VCC_1_3 = 16'sd5461;

endpackage

// File: rtl/schmitt_level_detector.sv
// 555-style hysteresis comparator on a strobed 16-bit sample stream.
// rise/fall flag the clk on which the registered level is about to change.
module schmitt_level_detector
  import discrete_pkg::*;
#(
  parameter logic signed [15:0] THRESH_HI = VCC_2_3,
  parameter logic signed [15:0] THRESH_LO = VCC_1_3
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic               level,
  output logic               rise,
  output logic               fall
);

  logic level_nxt;

  // Threshold decision; samples between the thresholds keep the old level
  always_comb begin
    level_nxt = level;
    if (audio_clk_en) begin
      if (in >= THRESH_HI) begin
        level_nxt = 1'b1;
      end else if (in < THRESH_LO) begin
        level_nxt = 1'b0;
      end
    end
  end

  // Comparator state
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      level <= 1'b0;
    end else begin
      level <= level_nxt;
    end
  end

  assign rise = ~level & level_nxt;
  assign fall = level & ~level_nxt;

endmodule

// File: rtl/square_wave_period_meter.sv
// Times high and low phases of a thresholded square wave in clk cycles.
// Publishes high/low/period on each complete cycle, flags stalls.
module square_wave_period_meter
  import discrete_pkg::*;
#(
  parameter int                 CLOCK_RATE     = 50000000,
  parameter logic signed [15:0] THRESH_HI      = VCC_2_3,
  parameter logic signed [15:0] THRESH_LO      = VCC_1_3,
  parameter int                 TIMEOUT_CYCLES = CLOCK_RATE / 10,
  parameter int                 COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   I_RSTn,
  input  logic                   audio_clk_en,
  input  logic signed [15:0]     in,
  output logic                   level,
  output logic [COUNT_WIDTH-1:0] high_cycles,
  output logic [COUNT_WIDTH-1:0] low_cycles,
  output logic [COUNT_WIDTH-1:0] period_cycles,
  output logic                   valid,
  output logic                   stalled
);

  localparam int W = COUNT_WIDTH;
  localparam logic [W-1:0] TMO = W'(TIMEOUT_CYCLES);

  meter_state_t state;
  meter_state_t state_nxt;

  logic         rise;
  logic         fall;
  logic [W-1:0] cnt;
  logic [W-1:0] len;
  logic [W-1:0] high_len;
  logic [W:0]   sum;
  logic         at_tmo;
  logic         publish;
  logic         capture;
  logic         stall;

  schmitt_level_detector #(
    .THRESH_HI(THRESH_HI),
    .THRESH_LO(THRESH_LO)
  ) u_det (
    .clk         (clk),
    .I_RSTn      (I_RSTn),
    .audio_clk_en(audio_clk_en),
    .in          (in),
    .level       (level),
    .rise        (rise),
    .fall        (fall)
  );

  assign len    = cnt + W'(1);
  assign at_tmo = (cnt == TMO);
  assign sum    = {1'b0, high_len} + {1'b0, len};

  // FSM state register
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state <= SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; an edge takes priority over a coincident timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC: begin
        if (rise) state_nxt = HIGH;
      end
      HIGH: begin
        if (fall)        state_nxt = LOW;
        else if (at_tmo) state_nxt = SYNC;
      end
      LOW: begin
        if (rise)        state_nxt = HIGH;
        else if (at_tmo) state_nxt = SYNC;
      end
      default: state_nxt = SYNC;
    endcase
  end

  // FSM action strobes
  always_comb begin
    publish = 1'b0;
    capture = 1'b0;
    stall   = 1'b0;
    unique case (state)
      HIGH: begin
        capture = fall;
        stall   = ~fall & at_tmo;
      end
      LOW: begin
        publish = rise;
        stall   = ~rise & at_tmo;
      end
      default: ;
    endcase
  end

  // Phase counter, cleared on every edge, saturating at the timeout
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      cnt <= '0;
    end else if (rise | fall) begin
      cnt <= '0;
    end else if (!at_tmo) begin
      cnt <= cnt + W'(1);
    end
  end

  // Holds the high-phase length until the closing rise
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      high_len <= '0;
    end else if (capture) begin
      high_len <= len;
    end
  end

  // Published results, valid pulse and stall flag
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      high_cycles   <= '0;
      low_cycles    <= '0;
      period_cycles <= '0;
      valid         <= 1'b0;
      stalled       <= 1'b0;
    end else begin
      valid <= publish;
      if (publish) begin
        high_cycles   <= high_len;
        low_cycles    <= len;
        period_cycles <= sum[W] ? '1 : sum[W-1:0];
        stalled       <= 1'b0;
      end else if (stall) begin
        high_cycles   <= '0;
        low_cycles    <= '0;
        period_cycles <= '0;
        stalled       <= 1'b1;
      end
    end
  end

endmodule
